// File: rtl/bolme_denetleyici_if.sv
`default_nettype none
// ============================================================================
// Module   : bolme_denetleyici_if
// Brief    : Start / operand / result handshake bundle between the AMB and
//            the multi-cycle divider sequencer.
// Revision : 1.0
// ============================================================================
interface bolme_denetleyici_if #(
   parameter int VERI_BIT = 32
);
   logic                baslat_i;
   logic [1:0]          islem_i;
   logic [VERI_BIT-1:0] bolunen_i;
   logic [VERI_BIT-1:0] bolen_i;
   logic                iptal_i;
   logic                kabul_i;
   logic                hazir_o;
   logic                mesgul_o;
   logic                gecerli_o;
   logic [VERI_BIT-1:0] sonuc_o;

   modport slave (
      input  baslat_i, islem_i, bolunen_i, bolen_i, iptal_i, kabul_i,
      output hazir_o, mesgul_o, gecerli_o, sonuc_o
   );

   modport master (
      output baslat_i, islem_i, bolunen_i, bolen_i, iptal_i, kabul_i,
      input  hazir_o, mesgul_o, gecerli_o, sonuc_o
   );
endinterface
`default_nettype wire

// File: rtl/bolme_denetleyici.sv
`default_nettype none
// ============================================================================
// Module   : bolme_denetleyici
// Brief    : Radix-2 restoring divider sequencer for DIV/DIVU/REM/REMU with
//            RISC-V divide-by-zero and overflow shortcuts. Optional result
//            cache enabled by macro BOLME_SONUC_ONBELLEK_EN.
// Revision : 1.0
// ============================================================================
module bolme_denetleyici #(
   parameter int VERI_BIT  = 32,
   parameter int SAYAC_BIT = 6
) (
   input  wire logic          clk_i,
   input  wire logic          rst_i,
   bolme_denetleyici_if.slave bus
);

   typedef enum logic [2:0] {
      BOSTA   = 3'd0,
      HAZIRLA = 3'd1,
      BOL     = 3'd2,
      DUZELT  = 3'd3,
      BITTI   = 3'd4
   } durum_t;

   durum_t               durum_q;
   logic [VERI_BIT-1:0]  bolum_q;
   logic [VERI_BIT-1:0]  bolen_q;
   logic [VERI_BIT:0]    kalan_q;
   logic [VERI_BIT-1:0]  sonuc_q;
   logic [1:0]           islem_q;
   logic                 bolum_isaret_q;
   logic                 kalan_isaret_q;
   logic [SAYAC_BIT-1:0] sayac_q;
   logic                 hazir_q;
   logic                 gecerli_q;

   logic [VERI_BIT+1:0]  w_kaydir;
   logic [VERI_BIT+1:0]  w_fark;
   logic [VERI_BIT:0]    kalan_d;
   logic [VERI_BIT-1:0]  bolum_d;
   logic [VERI_BIT-1:0]  w_bolum_son;
   logic [VERI_BIT-1:0]  w_kalan_son;
   logic                 w_sifir;
   logic                 w_tasma;
   logic [VERI_BIT-1:0]  w_ozel_sonuc;
   logic                 w_onb_isabet;
   logic [VERI_BIT-1:0]  w_onb_sonuc;

   // One restoring step: shift in the next dividend bit, keep the difference
   // only when the trial subtraction does not borrow.
   always_comb begin
      w_kaydir = {kalan_q, bolum_q[VERI_BIT-1]};
      w_fark   = w_kaydir - {2'b00, bolen_q};
      kalan_d  = w_fark[VERI_BIT+1] ? w_kaydir[VERI_BIT:0] : w_fark[VERI_BIT:0];
      bolum_d  = {bolum_q[VERI_BIT-2:0], ~w_fark[VERI_BIT+1]};
   end

   always_comb begin
      w_bolum_son = (!islem_q[0] && bolum_isaret_q) ? (~bolum_q + 1'b1) : bolum_q;
      w_kalan_son = (!islem_q[0] && kalan_isaret_q)
                    ? (~kalan_q[VERI_BIT-1:0] + 1'b1) : kalan_q[VERI_BIT-1:0];
   end

   always_comb begin
      w_sifir = (bus.bolen_i == '0);
      w_tasma = !bus.islem_i[0]
                && (bus.bolunen_i == {1'b1, {(VERI_BIT-1){1'b0}}})
                && (bus.bolen_i == '1);
      // Overflow: DIV returns the dividend itself (0x80000000), REM returns 0.
      if (w_sifir) begin
         w_ozel_sonuc = bus.islem_i[1] ? bus.bolunen_i : '1;
      end else begin
         w_ozel_sonuc = bus.islem_i[1] ? '0 : bus.bolunen_i;
      end
   end

`ifdef BOLME_SONUC_ONBELLEK_EN
   logic                onb_gecerli_q;
   logic                onb_isaretsiz_q;
   logic [VERI_BIT-1:0] onb_bolunen_q;
   logic [VERI_BIT-1:0] onb_bolen_q;
   logic [VERI_BIT-1:0] onb_bolum_q;
   logic [VERI_BIT-1:0] onb_kalan_q;
   logic [VERI_BIT-1:0] orj_bolunen_q;
   logic [VERI_BIT-1:0] orj_bolen_q;

   assign w_onb_isabet = onb_gecerli_q
                         && (bus.bolunen_i == onb_bolunen_q)
                         && (bus.bolen_i == onb_bolen_q)
                         && (bus.islem_i[0] == onb_isaretsiz_q);
   assign w_onb_sonuc  = bus.islem_i[1] ? onb_kalan_q : onb_bolum_q;
`else
   assign w_onb_isabet = 1'b0;
   assign w_onb_sonuc  = '0;
`endif

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         durum_q        <= BOSTA;
         bolum_q        <= '0;
         bolen_q        <= '0;
         kalan_q        <= '0;
         sonuc_q        <= '0;
         islem_q        <= '0;
         bolum_isaret_q <= 1'b0;
         kalan_isaret_q <= 1'b0;
         sayac_q        <= '0;
         hazir_q        <= 1'b1;
         gecerli_q      <= 1'b0;
`ifdef BOLME_SONUC_ONBELLEK_EN
         onb_gecerli_q   <= 1'b0;
         onb_isaretsiz_q <= 1'b0;
         onb_bolunen_q   <= '0;
         onb_bolen_q     <= '0;
         onb_bolum_q     <= '0;
         onb_kalan_q     <= '0;
         orj_bolunen_q   <= '0;
         orj_bolen_q     <= '0;
`endif
      end else if (bus.iptal_i) begin
         durum_q   <= BOSTA;
         hazir_q   <= 1'b1;
         gecerli_q <= 1'b0;
`ifdef BOLME_SONUC_ONBELLEK_EN
         if (durum_q == HAZIRLA || durum_q == BOL || durum_q == DUZELT) begin
            onb_gecerli_q <= 1'b0;
         end
`endif
      end else begin
         case (durum_q)
            BOSTA: begin
               if (bus.baslat_i) begin
                  islem_q <= bus.islem_i;
                  hazir_q <= 1'b0;
                  if (w_sifir || w_tasma) begin
                     sonuc_q   <= w_ozel_sonuc;
                     gecerli_q <= 1'b1;
                     durum_q   <= BITTI;
`ifdef BOLME_SONUC_ONBELLEK_EN
                     onb_gecerli_q <= 1'b0;
`endif
                  end else if (w_onb_isabet) begin
                     sonuc_q   <= w_onb_sonuc;
                     gecerli_q <= 1'b1;
                     durum_q   <= BITTI;
                  end else begin
                     bolum_q <= bus.bolunen_i;
                     bolen_q <= bus.bolen_i;
                     durum_q <= HAZIRLA;
`ifdef BOLME_SONUC_ONBELLEK_EN
                     orj_bolunen_q <= bus.bolunen_i;
                     orj_bolen_q   <= bus.bolen_i;
`endif
                  end
               end
            end

            HAZIRLA: begin
               if (!islem_q[0]) begin
                  bolum_q        <= bolum_q[VERI_BIT-1] ? (~bolum_q + 1'b1) : bolum_q;
                  bolen_q        <= bolen_q[VERI_BIT-1] ? (~bolen_q + 1'b1) : bolen_q;
                  bolum_isaret_q <= bolum_q[VERI_BIT-1] ^ bolen_q[VERI_BIT-1];
                  kalan_isaret_q <= bolum_q[VERI_BIT-1];
               end else begin
                  bolum_isaret_q <= 1'b0;
                  kalan_isaret_q <= 1'b0;
               end
               kalan_q <= '0;
               sayac_q <= SAYAC_BIT'(VERI_BIT);
               durum_q <= BOL;
            end

            BOL: begin
               kalan_q <= kalan_d;
               bolum_q <= bolum_d;
               sayac_q <= sayac_q - 1'b1;
               if (sayac_q == SAYAC_BIT'(1)) begin
                  durum_q <= DUZELT;
               end
            end

            DUZELT: begin
               sonuc_q   <= islem_q[1] ? w_kalan_son : w_bolum_son;
               gecerli_q <= 1'b1;
               durum_q   <= BITTI;
`ifdef BOLME_SONUC_ONBELLEK_EN
               onb_gecerli_q   <= 1'b1;
               onb_isaretsiz_q <= islem_q[0];
               onb_bolunen_q   <= orj_bolunen_q;
               onb_bolen_q     <= orj_bolen_q;
               onb_bolum_q     <= w_bolum_son;
               onb_kalan_q     <= w_kalan_son;
`endif
            end

            BITTI: begin
               if (bus.kabul_i) begin
                  durum_q   <= BOSTA;
                  hazir_q   <= 1'b1;
                  gecerli_q <= 1'b0;
               end
            end

            default: begin
               durum_q   <= BOSTA;
               hazir_q   <= 1'b1;
               gecerli_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.hazir_o   = hazir_q;
   assign bus.mesgul_o  = ~hazir_q;
   assign bus.gecerli_o = gecerli_q;
   assign bus.sonuc_o   = sonuc_q;

endmodule
`default_nettype wire

// File: tb/tb_bolme_denetleyici.sv
`default_nettype none
// ============================================================================
// Module   : tb_bolme_denetleyici
// Brief    : Directed vector table plus hand sequences for hold, flush and
//            asynchronous reset of the divider sequencer.
// Revision : 1.0
// ============================================================================
module tb_bolme_denetleyici;

`ifdef BOLME_SONUC_ONBELLEK_EN
   localparam int ONB = 1;
`else
   localparam int ONB = 0;
`endif

   logic clk;
   logic rst;
   int   hata;
   int   toplam;

   bolme_denetleyici_if #(.VERI_BIT(32)) bus ();

   bolme_denetleyici #(.VERI_BIT(32), .SAYAC_BIT(6)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] bek;
      int          tur;   // 0: iterative, 1: shortcut, 2: shortcut only with cache
   } vektor_t;

   vektor_t tablo [16];

   task automatic kontrol(input string ad, input logic [31:0] gercek, input logic [31:0] beklenen);
      toplam++;
      if (gercek !== beklenen) begin
         hata++;
         $display("FAIL %s: actual=%h expected=%h", ad, gercek, beklenen);
      end
   endtask

   // Called #1 after a rising edge with the DUT idle; returns once gecerli_o
   // is seen, counting edges inclusive of the accepting edge.
   task automatic calistir(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] s, output int lat);
      bus.islem_i   = op;
      bus.bolunen_i = a;
      bus.bolen_i   = b;
      bus.baslat_i  = 1'b1;
      @(posedge clk);
      lat = 1;
      #1;
      bus.baslat_i = 1'b0;
      while (!bus.gecerli_o && lat < 100) begin
         @(posedge clk);
         lat++;
         #1;
      end
      s = bus.sonuc_o;
   endtask

   task automatic kabul_et;
      bus.kabul_i = 1'b1;
      @(posedge clk);
      #1;
      bus.kabul_i = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] s;
      int          lat;
      int          bek_lat;

      hata   = 0;
      toplam = 0;

      tablo[0]  = '{2'b01, 32'd100,        32'd7,          32'd14,         0};
      tablo[1]  = '{2'b11, 32'd100,        32'd7,          32'd2,          2};
      tablo[2]  = '{2'b00, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  0};
      tablo[3]  = '{2'b10, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  2};
      tablo[4]  = '{2'b10, 32'd7,          32'hFFFF_FFFE,  32'd1,          0};
      tablo[5]  = '{2'b00, 32'd5,          32'd0,          32'hFFFF_FFFF,  1};
      tablo[6]  = '{2'b11, 32'd5,          32'd0,          32'd5,          1};
      tablo[7]  = '{2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1};
      tablo[8]  = '{2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1};
      tablo[9]  = '{2'b01, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          0};
      tablo[10] = '{2'b00, 32'd1000,       32'd33,         32'd30,         0};
      tablo[11] = '{2'b10, 32'd1000,       32'd33,         32'd10,         2};
      tablo[12] = '{2'b01, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  0};
      tablo[13] = '{2'b00, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         0};
      tablo[14] = '{2'b10, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'hFFFF_FFFE,  2};
      tablo[15] = '{2'b01, 32'd0,          32'd5,          32'd0,          0};

      bus.baslat_i  = 1'b0;
      bus.islem_i   = 2'b00;
      bus.bolunen_i = '0;
      bus.bolen_i   = '0;
      bus.iptal_i   = 1'b0;
      bus.kabul_i   = 1'b0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      kontrol("reset_hazir",   32'(bus.hazir_o),   32'd1);
      kontrol("reset_mesgul",  32'(bus.mesgul_o),  32'd0);
      kontrol("reset_gecerli", 32'(bus.gecerli_o), 32'd0);
      kontrol("reset_sonuc",   bus.sonuc_o,        32'd0);
      @(posedge clk);
      #1;

      for (int i = 0; i < 16; i++) begin
         calistir(tablo[i].op, tablo[i].a, tablo[i].b, s, lat);
         if (tablo[i].tur == 1 || (tablo[i].tur == 2 && ONB == 1)) bek_lat = 1;
         else bek_lat = 35;
         kontrol($sformatf("vec%0d_sonuc", i), s, tablo[i].bek);
         kontrol($sformatf("vec%0d_gecikme", i), 32'(lat), 32'(bek_lat));
         kabul_et();
         kontrol($sformatf("vec%0d_hazir", i), 32'(bus.hazir_o), 32'd1);
      end

      // Result must be held while the consumer stalls.
      calistir(2'b01, 32'd100, 32'd7, s, lat);
      kontrol("tut_gecikme", 32'(lat), 32'd35);
      for (int k = 0; k < 10; k++) begin
         @(posedge clk);
         #1;
         kontrol($sformatf("tut%0d_gecerli", k), 32'(bus.gecerli_o), 32'd1);
         kontrol($sformatf("tut%0d_sonuc", k), bus.sonuc_o, 32'd14);
      end
      kabul_et();
      kontrol("tut_hazir",   32'(bus.hazir_o),   32'd1);
      kontrol("tut_gecerli", 32'(bus.gecerli_o), 32'd0);

      // Flush at BOL cycle 10.
      bus.islem_i   = 2'b01;
      bus.bolunen_i = 32'd1000;
      bus.bolen_i   = 32'd3;
      bus.baslat_i  = 1'b1;
      @(posedge clk);
      #1;
      bus.baslat_i = 1'b0;
      kontrol("iptal_mesgul", 32'(bus.mesgul_o), 32'd1);
      repeat (10) @(posedge clk);
      #1;
      kontrol("iptal_oncesi_hazir", 32'(bus.hazir_o), 32'd0);
      bus.iptal_i = 1'b1;
      @(posedge clk);
      #1;
      bus.iptal_i = 1'b0;
      kontrol("iptal_hazir", 32'(bus.hazir_o), 32'd1);
      begin
         int yukseldi = 0;
         for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (bus.gecerli_o) yukseldi = 1;
         end
         kontrol("iptal_gecerli_yok", 32'(yukseldi), 32'd0);
      end

      // Flush while holding a result drops it.
      calistir(2'b01, 32'd9, 32'd3, s, lat);
      kontrol("iptal_bitti_sonuc", s, 32'd3);
      bus.iptal_i = 1'b1;
      @(posedge clk);
      #1;
      bus.iptal_i = 1'b0;
      kontrol("iptal_bitti_gecerli", 32'(bus.gecerli_o), 32'd0);
      kontrol("iptal_bitti_hazir",   32'(bus.hazir_o),   32'd1);

      // Asynchronous reset in the middle of BOL.
      bus.islem_i   = 2'b01;
      bus.bolunen_i = 32'd1000;
      bus.bolen_i   = 32'd33;
      bus.baslat_i  = 1'b1;
      @(posedge clk);
      #1;
      bus.baslat_i = 1'b0;
      repeat (15) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      kontrol("async_hazir",   32'(bus.hazir_o),   32'd1);
      kontrol("async_mesgul",  32'(bus.mesgul_o),  32'd0);
      kontrol("async_gecerli", 32'(bus.gecerli_o), 32'd0);
      kontrol("async_sonuc",   bus.sonuc_o,        32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      calistir(2'b10, 32'd1000, 32'd33, s, lat);
      kontrol("reset_sonrasi_sonuc",   s,         32'd10);
      kontrol("reset_sonrasi_gecikme", 32'(lat),  32'd35);
      kabul_et();

      $display("Result: errors=%0d of %0d checks", hata, toplam);
      $finish;
   end

endmodule
`default_nettype wire
